onehot_decoder_seq: RTL

- Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder. It is the successor to the team's fixed 4-to-16 gate-level decoder.
- Adds an output register, a global enable, selectable pulse/hold output, and a built-in scan sequencer that walks the one-hot output across all lines.
- Drives row/strobe selects in the team's test and display fabrics from either a host-supplied address or an autonomous sweep.

---
 rtl/onehot_decoder_seq_if.sv | 27 ++
 rtl/onehot_decoder_seq.sv | 85 ++++++++
 2 files changed

// File: rtl/onehot_decoder_seq_if.sv
// Request/response bundle for the registered one-hot decoder.
// The master drives requests; the slave (decoder) drives dout/busy/done.
interface onehot_decoder_seq_if #(
    parameter int unsigned SEL_W = 4
) ();
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic             en;
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             hold;
    logic             scan_start;
    logic             scan_stop;
    logic [OUT_W-1:0] dout;
    logic             busy;
    logic             done;

    modport master (
        output en, sel_valid, sel, hold, scan_start, scan_stop,
        input  dout, busy, done
    );

    modport slave (
        input  en, sel_valid, sel, hold, scan_start, scan_stop,
        output dout, busy, done
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with pulse/hold output,
// global enable and an autonomous single-sweep scan sequencer.
module onehot_decoder_seq #(
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned SCAN_DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_decoder_seq_if.slave  bus
);
    localparam int unsigned OUT_W   = 2 ** SEL_W;
    localparam int unsigned DWELL_W = 8;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
    localparam logic [SEL_W-1:0]   LINE_LAST  = SEL_W'(OUT_W - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic [SEL_W-1:0]   line;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   dout_r;
    logic               busy_r;
    logic               done_r;

    assign bus.dout = dout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            line   <= '0;
            dwell  <= '0;
            dout_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (!bus.en) begin
            // Blank the output and freeze the sequencer; requests are dropped.
            dout_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.scan_start) begin
                        state  <= SCAN;
                        line   <= '0;
                        dwell  <= '0;
                        dout_r <= OUT_W'(1);
                        busy_r <= 1'b1;
                    end else if (bus.sel_valid) begin
                        dout_r <= OUT_W'(1) << bus.sel;
                    end else if (!bus.hold) begin
                        dout_r <= '0;
                    end
                end
                SCAN: begin
                    if (bus.scan_stop) begin
                        state  <= IDLE;
                        dout_r <= '0;
                        busy_r <= 1'b0;
                    end else if (dout_r == '0) begin
                        // Blank output in SCAN means we are resuming after en=0.
                        dout_r <= OUT_W'(1) << line;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (line == LINE_LAST) begin
                            state  <= IDLE;
                            line   <= '0;
                            dout_r <= '0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            line   <= line + SEL_W'(1);
                            dout_r <= OUT_W'(1) << (line + SEL_W'(1));
                        end
                    end else begin
                        dwell <= dwell + DWELL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
